grf_scoreboard: RTL and testbench
=================================

Name: grf_scoreboard

Overview:
- Sequential hazard controller for the general register file (GRF) of the 5-stage pipelined MIPS core.
- Tracks, per architectural register, how many cycles remain until its in-flight value can be forwarded and until it is written back to the GRF.
- From that state it generates the D-stage stall for readers whose operand is not yet obtainable.
- Sits beside the D/E pipeline register: the writer is recorded as it moves D->E; readers are checked while in D.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hard-wired zero.
- TNEW_W, 2, width of the forward-ready countdown.
- TWB_W, 3, width of the write-back countdown.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- issue_valid  input  1  an instruction is entering E this edge and writes a register.
- issue_rd  input  5  destination register of the issuing instruction.
- issue_tnew  input  TNEW_W  cycles from E-entry until the result is forwardable.
- issue_twb  input  TWB_W  cycles from E-entry until the GRF write completes.
- rs_used  input  1  the D-stage instruction reads rs.
- rs_addr  input  5  rs register number.
- rs_tuse  input  2  cycles until rs is consumed (0 = consumed in D).
- rt_used  input  1  the D-stage instruction reads rt.
- rt_addr  input  5  rt register number.
- rt_tuse  input  2  cycles until rt is consumed.
- stall  output  1  freeze PC and F/D; insert a bubble into E.
- stall_rs  output  1  rs-caused stall (debug).
- stall_rt  output  1  rt-caused stall (debug).
- busy_mask  output  NREG  bit i set while register i has a pending write.

Behaviour:
- State: per register i, tnew_cnt[i] (TNEW_W bits) and wb_cnt[i] (TWB_W bits).
- An entry is pending while wb_cnt[i] != 0.
- Entry 0 is constant zero and never loaded.
- Reset: all counters go to 0 at the reset edge. stall, stall_rs and stall_rt are 0 in that cycle and after; busy_mask is 0 from the cycle following the reset edge.
- Reset overrides any issue in the same cycle.
- Per-edge update of every entry without an issue:
  - wb_cnt decrements, saturating at 0.
  - tnew_cnt decrements, saturating at 0.
  - When wb_cnt becomes 0, tnew_cnt is forced to 0.
- Issue load: on an edge with issue_valid=1, stall=0, issue_rd!=0 and issue_twb!=0:
  - wb_cnt[rd] <= issue_twb.
  - tnew_cnt[rd] <= min(issue_tnew, issue_twb).
  - Load wins over that entry's decrement.
- Issue ignored when any of these hold: stall=1 (the instruction is held in D; the bubble writes nothing), issue_rd=0, or issue_twb=0.
- Overwrite: a new issue to an already-pending register replaces its counters. The younger writer defines the architectural value.
- Stall decision, combinational from registered state and current D inputs:
  - stall_rs = rs_used & (rs_addr!=0) & (wb_cnt[rs_addr]!=0) & (tnew_cnt[rs_addr] > rs_tuse).
  - stall_rt is the same with the rt inputs.
  - stall = stall_rs | stall_rt.
- Same-cycle issue does not affect the same cycle's stall; the D-stage reader sees only state from earlier edges.
- rs_addr == rt_addr: both flags evaluate identically; no special case.
- busy_mask[i] = (wb_cnt[i]!=0); bit 0 is always 0. Purely combinational from state, so no added latency.
- Arithmetic is unsigned. No wrap-around is possible because every counter saturates at 0.

Test Plan:
- Load-use: issue rd=2, tnew=2, twb=3, then the next cycle a reader with rs=2, rs_tuse=1 -> stall=1 for exactly 1 cycle. busy_mask bit2 is set for 3 cycles, then clears.
- Branch after ALU: issue rd=5, tnew=1, twb=3, then the next cycle rt=5, rt_tuse=0 -> stall=1 and stall_rt=1 for 1 cycle, stall_rs=0. A reader of 5 with tuse=1 never stalls.
- Zero register: issue rd=0, tnew=2, twb=3, then reader rs=0, tuse=0 -> stall never asserts; busy_mask stays 0.
- Stall blocks issue: hold stall high via a pending rs=3 while presenting issue_valid with rd=7 -> busy_mask bit7 stays 0 until stall drops. Reissue then sets bit7.
- Overwrite and clamp: issue rd=4, tnew=2, twb=3, then the next cycle issue rd=4, tnew=3, twb=2 -> entry holds tnew=2, wb=2. busy_mask bit4 clears 2 cycles after the second issue.
- Reset mid-operation: with rd=2 and rd=9 pending and stall=1, assert reset together with issue_valid for rd=6 -> at the following cycle busy_mask=0, stall=0, and rd=6 is not recorded.

Source files
------------

// File: rtl/grf_scoreboard.sv
// GRF hazard scoreboard for the 5-stage MIPS pipeline.
// Each register keeps two countdowns: cycles until its in-flight result can be
// forwarded (tnew) and cycles until it lands in the GRF (wb). Writers are
// recorded as they move D->E; D-stage readers stall while their operand is
// pending and not forwardable by the time they consume it.
module grf_scoreboard #(
   parameter int NREG   = 32,
   parameter int TNEW_W = 2,
   parameter int TWB_W  = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              issue_valid,
   input  logic [4:0]        issue_rd,
   input  logic [TNEW_W-1:0] issue_tnew,
   input  logic [TWB_W-1:0]  issue_twb,
   input  logic              rs_used,
   input  logic [4:0]        rs_addr,
   input  logic [1:0]        rs_tuse,
   input  logic              rt_used,
   input  logic [4:0]        rt_addr,
   input  logic [1:0]        rt_tuse,
   output logic              stall,
   output logic              stall_rs,
   output logic              stall_rt,
   output logic [NREG-1:0]   busy_mask
);

   // Common widths for the min() clamp and for the tnew-vs-tuse compare.
   localparam int CW = (TNEW_W > TWB_W) ? TNEW_W : TWB_W;
   localparam int UW = (TNEW_W > 2) ? TNEW_W : 2;

   logic [TNEW_W-1:0] tnew_cnt [NREG];
   logic [TWB_W-1:0]  wb_cnt   [NREG];

   logic              issue_ok;
   logic [TNEW_W-1:0] issue_tnew_clamped;

   // Qualify the issue and clamp tnew so a result is never "forwardable"
   // after it has already been written back.
   always_comb begin
      issue_ok = issue_valid & ~stall & (issue_rd != 5'd0) & (issue_twb != '0);
      if (CW'(issue_tnew) <= CW'(issue_twb))
         issue_tnew_clamped = issue_tnew;
      else
         issue_tnew_clamped = TNEW_W'(issue_twb);
   end

   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_entry
         if (gi == 0) begin : g_zero
            // Register 0 is hard-wired zero and never has a pending write.
            assign tnew_cnt[gi] = '0;
            assign wb_cnt[gi]   = '0;
         end else begin : g_cnt
            logic [TNEW_W-1:0] tnew_reg;
            logic [TWB_W-1:0]  wb_reg;
            logic [TNEW_W-1:0] tnew_next;
            logic [TWB_W-1:0]  wb_next;
            logic              load;

            // Next counters: load from the issuing writer, otherwise count
            // down to zero; tnew is dropped once the write-back completes.
            always_comb begin
               load    = issue_ok & (issue_rd == 5'(gi));
               wb_next = (wb_reg != '0) ? wb_reg - 1'b1 : '0;
               if (wb_next == '0)
                  tnew_next = '0;
               else
                  tnew_next = (tnew_reg != '0) ? tnew_reg - 1'b1 : '0;
               if (load) begin
                  wb_next   = issue_twb;
                  tnew_next = issue_tnew_clamped;
               end
            end

            // Per-register countdown state.
            always_ff @(posedge clk) begin
               if (reset) begin
                  tnew_reg <= '0;
                  wb_reg   <= '0;
               end else begin
                  tnew_reg <= tnew_next;
                  wb_reg   <= wb_next;
               end
            end

            assign tnew_cnt[gi] = tnew_reg;
            assign wb_cnt[gi]   = wb_reg;
         end

         assign busy_mask[gi] = (wb_cnt[gi] != '0);
      end
   endgenerate

   // D-stage stall: operand pending and not forwardable by its use point.
   // Held low during reset so nothing is frozen while the pipe is cleared.
   always_comb begin
      stall_rs = ~reset & rs_used & (rs_addr != 5'd0) & (wb_cnt[rs_addr] != '0)
               & (UW'(tnew_cnt[rs_addr]) > UW'(rs_tuse));
      stall_rt = ~reset & rt_used & (rt_addr != 5'd0) & (wb_cnt[rt_addr] != '0)
               & (UW'(tnew_cnt[rt_addr]) > UW'(rt_tuse));
      stall    = stall_rs | stall_rt;
   end

endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed bench for grf_scoreboard: inputs change 1 time unit after each
// rising edge, outputs are checked 1 time unit later.
module tb_grf_scoreboard;

   logic        clk = 1'b0;
   logic        reset;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic [1:0]  issue_tnew;
   logic [2:0]  issue_twb;
   logic        rs_used;
   logic [4:0]  rs_addr;
   logic [1:0]  rs_tuse;
   logic        rt_used;
   logic [4:0]  rt_addr;
   logic [1:0]  rt_tuse;
   logic        stall;
   logic        stall_rs;
   logic        stall_rt;
   logic [31:0] busy_mask;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   grf_scoreboard #(.NREG(32), .TNEW_W(2), .TWB_W(3)) dut (
      .clk        (clk),
      .reset      (reset),
      .issue_valid(issue_valid),
      .issue_rd   (issue_rd),
      .issue_tnew (issue_tnew),
      .issue_twb  (issue_twb),
      .rs_used    (rs_used),
      .rs_addr    (rs_addr),
      .rs_tuse    (rs_tuse),
      .rt_used    (rt_used),
      .rt_addr    (rt_addr),
      .rt_tuse    (rt_tuse),
      .stall      (stall),
      .stall_rs   (stall_rs),
      .stall_rt   (stall_rt),
      .busy_mask  (busy_mask)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Advance past the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic issue(input logic v, input logic [4:0] rd, input logic [1:0] tn, input logic [2:0] tw);
      issue_valid = v; issue_rd = rd; issue_tnew = tn; issue_twb = tw;
   endtask

   task automatic rs(input logic u, input logic [4:0] a, input logic [1:0] t);
      rs_used = u; rs_addr = a; rs_tuse = t;
   endtask

   task automatic rt(input logic u, input logic [4:0] a, input logic [1:0] t);
      rt_used = u; rt_addr = a; rt_tuse = t;
   endtask

   initial begin
      reset = 1'b1;
      issue(0, 0, 0, 0);
      rs(0, 0, 0);
      rt(0, 0, 0);
      cyc();
      settle();
      chk("rst_stall", 32'(stall), 32'd0);
      cyc();
      reset = 1'b0;
      settle();
      chk("rst_busy", busy_mask, 32'h0);
      chk("rst_stall2", 32'(stall), 32'd0);

      // Load-use: rd=2 tnew=2 twb=3, reader rs=2 tuse=1.
      issue(1, 2, 2, 3);
      settle();
      chk("lu_issue_stall", 32'(stall), 32'd0);
      cyc();
      issue(0, 0, 0, 0);
      rs(1, 2, 1);
      settle();
      chk("lu_stall1", 32'(stall), 32'd1);
      chk("lu_busy1", busy_mask, 32'h4);
      cyc(); settle();
      chk("lu_stall2", 32'(stall), 32'd0);
      chk("lu_busy2", busy_mask, 32'h4);
      cyc(); settle();
      chk("lu_busy3", busy_mask, 32'h4);
      cyc(); settle();
      chk("lu_busy4", busy_mask, 32'h0);
      rs(0, 0, 0);

      // Branch after ALU: rd=5 tnew=1 twb=3; rt tuse=0 stalls, rs tuse=1 does not.
      issue(1, 5, 1, 3);
      cyc();
      issue(0, 0, 0, 0);
      rt(1, 5, 0);
      rs(1, 5, 1);
      settle();
      chk("br_stall", 32'(stall), 32'd1);
      chk("br_stall_rt", 32'(stall_rt), 32'd1);
      chk("br_stall_rs", 32'(stall_rs), 32'd0);
      cyc(); settle();
      chk("br_stall_end", 32'(stall), 32'd0);
      chk("br_busy", busy_mask, 32'h20);
      cyc(); cyc(); settle();
      chk("br_drain", busy_mask, 32'h0);
      rs(0, 0, 0);
      rt(0, 0, 0);

      // Zero register writes are ignored.
      issue(1, 0, 2, 3);
      cyc();
      issue(0, 0, 0, 0);
      rs(1, 0, 0);
      settle();
      chk("z_stall", 32'(stall), 32'd0);
      chk("z_busy", busy_mask, 32'h0);
      cyc(); settle();
      chk("z_busy2", busy_mask, 32'h0);
      rs(0, 0, 0);

      // Stall blocks issue: rd=3 tnew=3 twb=3, reader rs=3 tuse=0 with rd=7 waiting.
      issue(1, 3, 3, 3);
      cyc();
      issue(1, 7, 1, 2);
      rs(1, 3, 0);
      settle();
      chk("sb_stall1", 32'(stall), 32'd1);
      cyc(); settle();
      chk("sb_stall2", 32'(stall), 32'd1);
      chk("sb_busy7_a", 32'(busy_mask[7]), 32'd0);
      cyc(); settle();
      chk("sb_stall3", 32'(stall), 32'd1);
      chk("sb_busy7_b", 32'(busy_mask[7]), 32'd0);
      cyc(); settle();
      chk("sb_stall4", 32'(stall), 32'd0);
      chk("sb_busy7_c", 32'(busy_mask[7]), 32'd0);
      cyc();
      issue(0, 0, 0, 0);
      rs(0, 0, 0);
      settle();
      chk("sb_busy7_set", busy_mask, 32'h80);
      cyc(); cyc(); settle();
      chk("sb_drain", busy_mask, 32'h0);

      // Overwrite and clamp: rd=4 (2,3) then rd=4 (3,2) -> tnew=2, wb=2.
      issue(1, 4, 2, 3);
      cyc();
      issue(1, 4, 3, 2);
      cyc();
      issue(0, 0, 0, 0);
      rs(1, 4, 1);
      rt(1, 4, 2);
      settle();
      chk("ow_stall_rs", 32'(stall_rs), 32'd1);
      chk("ow_stall_rt", 32'(stall_rt), 32'd0);
      chk("ow_busy1", busy_mask, 32'h10);
      cyc(); settle();
      chk("ow_stall_rs2", 32'(stall_rs), 32'd0);
      chk("ow_busy2", busy_mask, 32'h10);
      cyc(); settle();
      chk("ow_busy3", busy_mask, 32'h0);
      rs(0, 0, 0);
      rt(0, 0, 0);

      // Reset mid-operation with rd=2, rd=9 pending and a stalled reader.
      issue(1, 2, 3, 3);
      cyc();
      issue(1, 9, 3, 3);
      cyc();
      issue(0, 0, 0, 0);
      rs(1, 9, 0);
      settle();
      chk("rm_stall", 32'(stall), 32'd1);
      chk("rm_busy", busy_mask, 32'h204);
      reset = 1'b1;
      issue(1, 6, 1, 3);
      settle();
      chk("rm_stall_rst", 32'(stall), 32'd0);
      cyc();
      reset = 1'b0;
      issue(0, 0, 0, 0);
      settle();
      chk("rm_busy_clr", busy_mask, 32'h0);
      chk("rm_stall_clr", 32'(stall), 32'd0);
      cyc(); settle();
      chk("rm_no_rd6", busy_mask, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
